// File: rtl/fir_tap_sequencer_if.sv
// Host coefficient-update handshake plus the shared SRAM bank bus.
// The host side takes the master modport and the sequencer the slave modport.
interface fir_tap_sequencer_if #(
  parameter int P_NUM_BANKS = 4,
  parameter int P_ADDR_W    = 4,
  parameter int P_DATA_W    = 16
);
  logic                   iUpdValid;
  logic [5:0]             iUpdAddr;
  logic [P_DATA_W-1:0]    iUpdData;
  logic                   oUpdReady;
  logic [P_NUM_BANKS-1:0] oCsnRam;
  logic                   oWrnRam;
  logic [P_ADDR_W-1:0]    oAddrRam;
  logic [1:0]             oModuleSel;
  logic [P_DATA_W-1:0]    oWtDtRam;

  modport master (
    output iUpdValid, iUpdAddr, iUpdData,
    input  oUpdReady, oCsnRam, oWrnRam, oAddrRam, oModuleSel, oWtDtRam
  );

  modport slave (
    input  iUpdValid, iUpdAddr, iUpdData,
    output oUpdReady, oCsnRam, oWrnRam, oAddrRam, oModuleSel, oWtDtRam
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// FIR coefficient-store sequencer: per-sample tap read sweep with MAC gating,
// and host coefficient writes between samples.
module fir_tap_sequencer #(
  parameter int P_NUM_TAPS  = 10,
  parameter int P_NUM_BANKS = 4,
  parameter int P_ADDR_W    = 4,
  parameter int P_DATA_W    = 16
) (
  input  logic               iClk12M,
  input  logic               iRsn,
  input  logic               iEnSample600k,
  input  logic               iCoeffUpdateFlag,
  input  logic               iErrClr,
  fir_tap_sequencer_if.slave bus,
  output logic               oEnMAC,
  output logic               oAccClr,
  output logic               oMacDone,
  output logic               oBusy,
  output logic               oOverrun,
  output logic               oUpdErr
);

  typedef enum logic [2:0] {IDLE, CLR, READ, DRAIN, UPDATE} state_t;

  localparam logic [3:0]          L_TAP_LIMIT = 4'(P_NUM_TAPS);
  localparam logic [P_ADDR_W-1:0] L_LAST_TAP  = P_ADDR_W'(P_NUM_TAPS - 1);

  state_t                 state, nextState;
  logic [P_ADDR_W-1:0]    tapCnt, tapCntD;
  logic [P_NUM_BANKS-1:0] csnD;
  logic                   wrnD;
  logic [P_ADDR_W-1:0]    addrD;
  logic [1:0]             selD;
  logic [P_DATA_W-1:0]    dataD;
  logic                   enMacD, accClrD, macDoneD, busyD, readyD, overrunD, updErrD;

  logic [1:0] updBank;
  logic [3:0] updTap;
  logic       wrFire, tapLegal, lastTap, missedStrike;

  assign updBank      = bus.iUpdAddr[5:4];
  assign updTap       = bus.iUpdAddr[3:0];
  assign wrFire       = bus.iUpdValid & bus.oUpdReady;
  assign tapLegal     = (updTap < L_TAP_LIMIT);
  assign lastTap      = (tapCnt == L_LAST_TAP);
  // A strike is only usable from IDLE and only when no update is requested.
  assign missedStrike = iEnSample600k & ((state != IDLE) | iCoeffUpdateFlag);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iCoeffUpdateFlag) nextState = UPDATE;
               else if (iEnSample600k) nextState = CLR;
      CLR:     nextState = READ;
      READ:    if (lastTap) nextState = DRAIN;
      DRAIN:   nextState = IDLE;
      UPDATE:  if (!iCoeffUpdateFlag) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so that, once registered,
  // they line up with the state they describe.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    csnD     = '1;
    wrnD     = 1'b1;
    addrD    = bus.oAddrRam;
    selD     = bus.oModuleSel;
    dataD    = bus.oWtDtRam;
    tapCntD  = tapCnt;
    accClrD  = (nextState == CLR);
    busyD    = (nextState inside {CLR, READ, DRAIN});
    enMacD   = (state == READ);
    macDoneD = (state == DRAIN);
    readyD   = (nextState == UPDATE);
    overrunD = missedStrike ? 1'b1 : (iErrClr ? 1'b0 : oOverrun);
    updErrD  = (wrFire && !tapLegal) ? 1'b1 : (iErrClr ? 1'b0 : oUpdErr);

    case (nextState)
      CLR:  tapCntD = '0;
      READ: begin
        if (state == READ) tapCntD = tapCnt + 1'b1;
        csnD  = '0;
        addrD = tapCntD;
      end
      default: ;
    endcase

    // A write accepted on the exit edge of UPDATE still lands here.
    if (wrFire && tapLegal) begin
      csnD  = ~(P_NUM_BANKS'(1) << updBank);
      wrnD  = 1'b0;
      addrD = P_ADDR_W'(updTap);
      selD  = updBank;
      dataD = bus.iUpdData;
    end
  end

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state          <= IDLE;
      tapCnt         <= '0;
      bus.oCsnRam    <= '1;
      bus.oWrnRam    <= 1'b1;
      bus.oAddrRam   <= '0;
      bus.oModuleSel <= '0;
      bus.oWtDtRam   <= '0;
      bus.oUpdReady  <= 1'b0;
      oEnMAC         <= 1'b0;
      oAccClr        <= 1'b0;
      oMacDone       <= 1'b0;
      oBusy          <= 1'b0;
      oOverrun       <= 1'b0;
      oUpdErr        <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state          <= nextState;
      tapCnt         <= tapCntD;
      bus.oCsnRam    <= csnD;
      bus.oWrnRam    <= wrnD;
      bus.oAddrRam   <= addrD;
      bus.oModuleSel <= selD;
      bus.oWtDtRam   <= dataD;
      bus.oUpdReady  <= readyD;
      oEnMAC         <= enMacD;
      oAccClr        <= accClrD;
      oMacDone       <= macDoneD;
      oBusy          <= busyD;
      oOverrun       <= overrunD;
      oUpdErr        <= updErrD;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: per-cycle expected records are queued
// when stimulus is driven and compared as the DUT reaches each cycle.
module tb_fir_tap_sequencer;

  logic iClk12M, iRsn, iEnSample600k, iCoeffUpdateFlag, iErrClr;
  logic oEnMAC, oAccClr, oMacDone, oBusy, oOverrun, oUpdErr;

  fir_tap_sequencer_if #(.P_NUM_BANKS(4), .P_ADDR_W(4), .P_DATA_W(16)) bus ();

  fir_tap_sequencer #(
    .P_NUM_TAPS(10), .P_NUM_BANKS(4), .P_ADDR_W(4), .P_DATA_W(16)
  ) dut (
    .iClk12M          (iClk12M),
    .iRsn             (iRsn),
    .iEnSample600k    (iEnSample600k),
    .iCoeffUpdateFlag (iCoeffUpdateFlag),
    .iErrClr          (iErrClr),
    .bus              (bus),
    .oEnMAC           (oEnMAC),
    .oAccClr          (oAccClr),
    .oMacDone         (oMacDone),
    .oBusy            (oBusy),
    .oOverrun         (oOverrun),
    .oUpdErr          (oUpdErr)
  );

  typedef struct {
    int         cyc;
    logic [3:0] csn;
    logic       wrn, en, clr, done, busy;
    bit         chkAddr;
    logic [3:0] addr;
    bit         chkWr;
    logic [1:0] sel;
    logic [15:0] data;
  } rec_t;

  rec_t expQ[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   doneCnt = 0;
  int   c0;
  logic expReady = 1'b0, expOverrun = 1'b0, expUpdErr = 1'b0;

  initial iClk12M = 1'b0;
  always #5 iClk12M = ~iClk12M;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t idle_rec(input int c);
    rec_t r;
    r = '{default: '0};
    r.cyc = c;
    r.csn = 4'hF;
    r.wrn = 1'b1;
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk(tag, {30'd0, bus.oCsnRam, bus.oWrnRam, bus.oAddrRam, bus.oModuleSel, bus.oWtDtRam,
              oEnMAC, oAccClr, oMacDone, oBusy, bus.oUpdReady, oOverrun, oUpdErr},
             {30'd0, 4'hF, 1'b1, 4'h0, 2'h0, 16'h0, 7'b0});
  endtask

  // One clock: outputs are sampled 1 time unit after the edge.
  task automatic tick();
    rec_t r;
    logic [8:0] seqObs;
    @(posedge iClk12M);
    #1;
    cyc++;
    seqObs = {bus.oCsnRam, bus.oWrnRam, oEnMAC, oAccClr, oMacDone, oBusy};
    if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
      r = expQ.pop_front();
      chk("seq", 64'(seqObs), 64'({r.csn, r.wrn, r.en, r.clr, r.done, r.busy}));
      if (r.chkAddr) chk("addr", 64'(bus.oAddrRam), 64'(r.addr));
      if (r.chkWr) chk("wrdata", 64'({bus.oModuleSel, bus.oWtDtRam}), 64'({r.sel, r.data}));
    end else begin
      chk("idle", 64'(seqObs), 64'({4'hF, 1'b1, 4'b0000}));
    end
    chk("flags", 64'({bus.oUpdReady, oOverrun, oUpdErr}), 64'({expReady, expOverrun, expUpdErr}));
    if (oMacDone) doneCnt++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Strike sampled at the coming edge (index cyc): 13-cycle sequence follows.
  task automatic do_strike();
    rec_t r;
    int c;
    c = cyc;
    r = idle_rec(c + 1); r.clr = 1'b1; r.busy = 1'b1; expQ.push_back(r);
    for (int i = 0; i < 10; i++) begin
      r = idle_rec(c + 2 + i);
      r.csn = 4'h0; r.busy = 1'b1; r.en = (i > 0);
      r.chkAddr = 1'b1; r.addr = 4'(i);
      expQ.push_back(r);
    end
    r = idle_rec(c + 12); r.en = 1'b1; r.busy = 1'b1; expQ.push_back(r);
    r = idle_rec(c + 13); r.done = 1'b1; expQ.push_back(r);
    iEnSample600k = 1'b1;
    tick();
    iEnSample600k = 1'b0;
  endtask

  // Present one write for the coming edge; expCsn 4'hF means it must be rejected.
  task automatic do_write(input logic [5:0] a, input logic [15:0] d, input logic [3:0] expCsn);
    rec_t r;
    r = idle_rec(cyc + 1);
    if (expCsn != 4'hF) begin
      r.csn = expCsn; r.wrn = 1'b0;
      r.chkAddr = 1'b1; r.addr = a[3:0];
      r.chkWr = 1'b1; r.sel = a[5:4]; r.data = d;
    end else begin
      expUpdErr = 1'b1;
    end
    expQ.push_back(r);
    bus.iUpdValid = 1'b1;
    bus.iUpdAddr  = a;
    bus.iUpdData  = d;
    tick();
  endtask

  initial begin
    iRsn = 1'b0; iEnSample600k = 1'b0; iCoeffUpdateFlag = 1'b0; iErrClr = 1'b0;
    bus.iUpdValid = 1'b0; bus.iUpdAddr = '0; bus.iUpdData = '0;
    #12;
    check_reset("reset_values");
    iRsn = 1'b1;
    run(3);

    // Single strike: full 13-cycle timing.
    do_strike();
    run(14);

    // 50 samples at the nominal 20-cycle spacing.
    doneCnt = 0;
    for (int s = 0; s < 50; s++) begin
      do_strike();
      run(19);
    end
    chk("done_count_50", 64'(doneCnt), 64'd50);

    // Strike in the oMacDone cycle is accepted.
    do_strike();
    run(12);
    do_strike();
    run(14);

    // Strike 5 cycles into a sequence: overrun, sequence unchanged, then clear.
    do_strike();
    run(4);
    iEnSample600k = 1'b1; expOverrun = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    run(9);
    iErrClr = 1'b1; expOverrun = 1'b0;
    tick();
    iErrClr = 1'b0;
    run(2);

    // Update mode: back-to-back writes, illegal tap, set-beats-clear.
    iCoeffUpdateFlag = 1'b1; expReady = 1'b1;
    tick();
    do_write(6'h25, 16'hABCD, 4'b1011);
    do_write(6'h09, 16'h1234, 4'b1110);
    bus.iUpdValid = 1'b0;
    tick();
    do_write(6'h1C, 16'h0BAD, 4'hF);
    bus.iUpdValid = 1'b0;
    tick();
    iErrClr = 1'b1; expUpdErr = 1'b0;
    tick();
    do_write(6'h1A, 16'h0BAD, 4'hF);
    bus.iUpdValid = 1'b0; iErrClr = 1'b0;
    tick();
    iErrClr = 1'b1; expUpdErr = 1'b0;
    tick();
    iErrClr = 1'b0;
    // Write accepted on the same edge the flag drops still completes.
    iCoeffUpdateFlag = 1'b0; expReady = 1'b0;
    do_write(6'h33, 16'h5555, 4'b0111);
    bus.iUpdValid = 1'b0;
    run(2);

    // Flag rises during READ: sequence completes, then UPDATE.
    c0 = cyc;
    do_strike();
    run(4);
    iCoeffUpdateFlag = 1'b1;
    while (cyc < c0 + 13) tick();
    expReady = 1'b1;
    tick();
    iEnSample600k = 1'b1; expOverrun = 1'b1;
    tick();
    iEnSample600k = 1'b0;
    run(5);
    iCoeffUpdateFlag = 1'b0; expReady = 1'b0;
    tick();
    iErrClr = 1'b1; expOverrun = 1'b0;
    tick();
    iErrClr = 1'b0;

    // Flag and strike together in IDLE: flag wins, overrun set.
    iCoeffUpdateFlag = 1'b1; iEnSample600k = 1'b1; expReady = 1'b1; expOverrun = 1'b1;
    tick();
    iCoeffUpdateFlag = 1'b0; iEnSample600k = 1'b0; expReady = 1'b0;
    tick();
    iErrClr = 1'b1; expOverrun = 1'b0;
    tick();
    iErrClr = 1'b0;
    run(2);

    // Reset mid-READ aborts asynchronously with no oMacDone.
    do_strike();
    run(6);
    #2 iRsn = 1'b0;
    #1 check_reset("async_reset_mid_read");
    expQ.delete();
    run(2);
    iRsn = 1'b1;
    doneCnt = 0;
    run(15);
    chk("no_done_after_reset", 64'(doneCnt), 64'd0);
    do_strike();
    run(14);
    chk("done_after_reset", 64'(doneCnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
